// File: rtl/abs_dif_sched.sv
// Two-requester round-robin scheduler sharing one |a-b| datapath into a single-entry result register.
// Optional per-requester transfer counters are built when ABS_DIF_SCHED_STATS_EN is defined.
module abs_dif_sched #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         res_valid,
    output logic [N-1:0] res_data,
    output logic         res_id,
    input  logic         res_ready,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1,
    output logic         o_dbg_state
);

    // Handshake: a pair moves on reqX_valid & reqX_ready; a result leaves on res_valid & res_ready.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last_grant;
    logic [N-1:0] r_res_data;
    logic         r_res_id;

    logic         w_can_accept;
    logic         w_grant_valid;
    logic         w_grant_id;
    logic         w_xfer;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_diff;

    assign w_can_accept = (r_state == ST_EMPTY) || res_ready;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ~r_last_grant;
        end else if (req0_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b0;
        end else if (req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b1;
        end
    end

    assign req0_ready = w_can_accept && w_grant_valid && (w_grant_id == 1'b0);
    assign req1_ready = w_can_accept && w_grant_valid && (w_grant_id == 1'b1);
    assign w_xfer     = w_can_accept && w_grant_valid;

    // Subtract the smaller from the larger so the result always fits in N bits.
    assign w_a    = w_grant_id ? req1_a : req0_a;
    assign w_b    = w_grant_id ? req1_b : req0_b;
    assign w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_xfer)         w_state_nxt = ST_FULL;
                else if (res_ready) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_last_grant <= 1'b1;
            r_res_data   <= '0;
            r_res_id     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_last_grant <= w_grant_id;
                r_res_data   <= w_diff;
                r_res_id     <= w_grant_id;
            end
        end
    end

    assign res_valid   = (r_state == ST_FULL);
    assign res_data    = r_res_data;
    assign res_id      = r_res_id;
    assign o_dbg_state = r_state;

`ifdef ABS_DIF_SCHED_STATS_EN
    logic [7:0] r_cnt0;
    logic [7:0] r_cnt1;

    // Counters stick at 255 rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= 8'd0;
            r_cnt1 <= 8'd0;
        end else if (w_xfer) begin
            if (!w_grant_id && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
            if (w_grant_id && (r_cnt1 != 8'hFF))  r_cnt1 <= r_cnt1 + 8'd1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    assign cnt0 = 8'd0;
    assign cnt1 = 8'd0;
`endif

endmodule

// File: tb/tb_abs_dif_sched.sv
// Directed bench for abs_dif_sched: arbitration order, result hold, back-to-back flow, reset, counters.
module tb_abs_dif_sched;

    localparam int N = 4;
`ifdef ABS_DIF_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic         req0_valid;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_ready;
    logic         res_valid;
    logic [N-1:0] res_data;
    logic         res_id;
    logic         res_ready;
    logic [7:0]   cnt0;
    logic [7:0]   cnt1;
    logic         dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    abs_dif_sched #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .o_dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
        req0_valid = v;
        req0_a     = a;
        req0_b     = b;
    endtask

    task automatic drive1(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
        req1_valid = v;
        req1_a     = a;
        req1_b     = b;
    endtask

    // Requester-side protocol monitor: a pending pair must stay put until accepted.
    logic         p0 = 1'b0, p1 = 1'b0;
    logic [N-1:0] h0a, h0b, h1a, h1b;
    always @(posedge clk) begin
        if (rst_n && p0)
            assert (req0_valid && req0_a == h0a && req0_b == h0b)
            else $error("FAIL req0_hold: pending pair changed before ready");
        if (rst_n && p1)
            assert (req1_valid && req1_a == h1a && req1_b == h1b)
            else $error("FAIL req1_hold: pending pair changed before ready");
        p0  = rst_n && req0_valid && !req0_ready;
        p1  = rst_n && req1_valid && !req1_ready;
        h0a = req0_a;
        h0b = req0_b;
        h1a = req1_a;
        h1b = req1_b;
    end

    initial begin
        rst_n     = 1'b1;
        res_ready = 1'b0;
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(res_valid), 0);
        check("rst_data", 32'(res_data), 0);
        check("rst_id", 32'(res_id), 0);
        check("rst_cnt0", 32'(cnt0), 0);
        check("rst_cnt1", 32'(cnt1), 0);
        check("rst_ready0", 32'(req0_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Both valid after reset: requester 0 first, then requester 1
        res_ready = 1'b1;
        drive0(1'b1, 4'd9, 4'd3);
        drive1(1'b1, 4'd2, 4'd7);
        #1;
        check("first_ready0", 32'(req0_ready), 1);
        check("first_ready1", 32'(req1_ready), 0);
        tick();
        check("first_valid", 32'(res_valid), 1);
        check("first_data", 32'(res_data), 6);
        check("first_id", 32'(res_id), 0);
        drive0(1'b0, '0, '0);
        #1;
        check("second_ready1", 32'(req1_ready), 1);
        tick();
        check("second_data", 32'(res_data), 5);
        check("second_id", 32'(res_id), 1);
        drive1(1'b0, '0, '0);
        tick();
        check("drain_valid", 32'(res_valid), 0);
        check("drain_state", 32'(dbg_state), 0);

        // Round-robin alternation with no bubbles
        drive0(1'b1, 4'd5, 4'd1);
        drive1(1'b1, 4'd3, 4'd12);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) drive0(1'b0, '0, '0);
            #1;
            check("rr_ready0", 32'(req0_ready), (i % 2 == 0) ? 1 : 0);
            check("rr_ready1", 32'(req1_ready), (i % 2 == 1) ? 1 : 0);
            tick();
            check("rr_valid", 32'(res_valid), 1);
            check("rr_id", 32'(res_id), 32'(i % 2));
            check("rr_data", 32'(res_data), (i % 2 == 0) ? 4 : 9);
        end
        drive1(1'b0, '0, '0);
        tick();
        check("rr_drain", 32'(res_valid), 0);

        // Backpressure: result held, no ready while FULL and res_ready low
        res_ready = 1'b0;
        drive0(1'b1, 4'd15, 4'd0);
        #1;
        check("bp_ready0", 32'(req0_ready), 1);
        tick();
        drive0(1'b0, '0, '0);
        drive1(1'b1, 4'd1, 4'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_hold_ready1", 32'(req1_ready), 0);
            check("bp_hold_valid", 32'(res_valid), 1);
            check("bp_hold_data", 32'(res_data), 15);
            check("bp_hold_id", 32'(res_id), 0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_ready1", 32'(req1_ready), 1);
        tick();
        check("bp_b2b_valid", 32'(res_valid), 1);
        check("bp_b2b_data", 32'(res_data), 3);
        check("bp_b2b_id", 32'(res_id), 1);
        drive1(1'b0, '0, '0);
        tick();
        check("bp_drain", 32'(res_valid), 0);

        // Equal operands and full-range difference
        drive0(1'b1, 4'd10, 4'd10);
        tick();
        check("eq_data", 32'(res_data), 0);
        check("eq_id", 32'(res_id), 0);
        drive0(1'b1, 4'd0, 4'd15);
        tick();
        check("max_data", 32'(res_data), 15);
        drive0(1'b0, '0, '0);
        tick();

        // Asynchronous reset while FULL
        res_ready = 1'b0;
        drive0(1'b1, 4'd7, 4'd2);
        tick();
        drive0(1'b0, '0, '0);
        check("pre_rst_valid", 32'(res_valid), 1);
        check("pre_rst_data", 32'(res_data), 5);
        check("pre_rst_cnt0", 32'(cnt0), STATS ? 8 : 0);
        check("pre_rst_cnt1", 32'(cnt1), STATS ? 5 : 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(res_valid), 0);
        check("async_rst_data", 32'(res_data), 0);
        check("async_rst_cnt0", 32'(cnt0), 0);
        check("async_rst_cnt1", 32'(cnt1), 0);
        tick();
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        check("post_rst_valid", 32'(res_valid), 0);
        drive0(1'b1, 4'd1, 4'd9);
        drive1(1'b1, 4'd6, 4'd6);
        #1;
        check("post_rst_ready0", 32'(req0_ready), 1);
        check("post_rst_ready1", 32'(req1_ready), 0);
        tick();
        check("post_rst_id", 32'(res_id), 0);
        check("post_rst_data", 32'(res_data), 8);
        drive0(1'b0, '0, '0);
        tick();
        check("post_rst_id1", 32'(res_id), 1);
        check("post_rst_data1", 32'(res_data), 0);
        drive1(1'b0, '0, '0);
        tick();
        check("post_rst_drain", 32'(res_valid), 0);

        // Counter saturation: 300 transfers from requester 0 (one already counted above)
        check("sat_start_cnt0", 32'(cnt0), STATS ? 1 : 0);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        drive0(1'b1, 4'd2, 4'd1);
        for (int i = 0; i < 255; i++) tick();
        check("sat_255_cnt0", 32'(cnt0), STATS ? 255 : 0);
        for (int i = 0; i < 45; i++) tick();
        check("sat_300_cnt0", 32'(cnt0), STATS ? 255 : 0);
        check("sat_300_cnt1", 32'(cnt1), 0);
        drive0(1'b0, '0, '0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/abs_dif_sched.md
ABS_DIF_SCHED -- requirements
Module: abs_dif_sched

Interface
REQ-001 Parameter: N, default 4, operand and result width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  N each  requester 0 operands, unsigned.
REQ-006 req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  as REQ-004..006 for requester 1.
REQ-008 res_valid  output  1  result register holds a valid result.
REQ-009 res_data  output  N  |a-b| of the accepted pair.
REQ-010 res_id  output  1  index of the requester that produced res_data.
REQ-011 res_ready  input  1  consumer accepts the result this cycle.
REQ-012 cnt0, cnt1  output  8 each  per-requester accepted-pair counters (see Configuration).

Function
REQ-013 Block SHALL share one absolute-difference datapath between two requesters under round-robin arbitration, one pair per cycle maximum.
REQ-014 Output stage SHALL be a single-entry register with states EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-015 can_accept SHALL be 1 when state is EMPTY, or FULL with res_ready=1; otherwise 0.
REQ-016 Grant: only one valid -> that requester; both valid -> requester other than last_grant; neither -> no grant.
REQ-017 reqX_ready SHALL be 1 only for the granted requester and only when can_accept=1; at most one ready per cycle.
REQ-018 Transfer occurs on valid&ready; on transfer last_grant SHALL update to the granted index.
REQ-019 On transfer, res_data SHALL load max(a,b)-min(a,b) computed in N bits, res_id SHALL load the granted index, state goes to FULL; latency exactly 1 cycle from transfer to res_valid.
REQ-020 a==b SHALL yield res_data=0; result never exceeds 2^N-1; no carry out or sign is produced.
REQ-021 FULL with res_ready=0: res_data, res_id, res_valid SHALL hold stable; no ready asserted.
REQ-022 FULL with res_ready=1 and a transfer in the same cycle: new result loads, state stays FULL (back-to-back, no bubble).
REQ-023 FULL with res_ready=1 and no transfer: state goes to EMPTY.
REQ-024 Requesters keep valid and operands stable until ready; a bench assertion SHALL flag violations, the block need not tolerate them.
REQ-025 res_ready while EMPTY SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force state EMPTY, res_valid=0, res_data=0, res_id=0, last_grant=1, cnt0=cnt1=0, regardless of clk.
REQ-027 Reset mid-operation SHALL discard any held result; no partial result is emitted after release.
REQ-028 First arbitration after reset with both valid SHALL grant requester 0.

Configuration
REQ-029 Macro ABS_DIF_SCHED_STATS_EN: when defined, cnt0/cnt1 SHALL increment by 1 on each transfer from requester 0/1, saturating at 255.
REQ-030 Without ABS_DIF_SCHED_STATS_EN, cnt0 and cnt1 SHALL be tied to 0 and no counter registers exist; all other behaviour identical.

Verification
REQ-031 After reset, req0 (a=9,b=3) and req1 (a=2,b=7) both valid, res_ready=1 -> cycle1 req0_ready=1; next cycle res_data=6,res_id=0; following cycle res_data=5,res_id=1.
REQ-032 Both requesters valid continuously for 6 cycles, res_ready=1 -> res_id sequence 0,1,0,1,0,1 with res_valid=1 every cycle after first.
REQ-033 Single transfer (a=15,b=0) then res_ready=0 for 3 cycles with req1 valid -> res_data=15 held, req1_ready=0 throughout; res_ready=1 -> req1 accepted same cycle.
REQ-034 req0 a=b=10 -> res_data=0, res_id=0; a=0,b=15 -> res_data=15.
REQ-035 rst_n pulled low between clock edges while FULL -> res_valid=0 immediately, cnt0=cnt1=0; after release both valid -> requester 0 granted.
REQ-036 With ABS_DIF_SCHED_STATS_EN, 300 transfers from requester 0 -> cnt0=255, cnt1=0; without macro -> both 0.
